// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer codes, response codes,
// data-phase select and default-slave state encodings.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DSEL_NONE = 2'd0,
    DSEL_S1   = 2'd1,
    DSEL_S2   = 2'd2,
    DSEL_DEF  = 2'd3
  } dsel_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dstate_e;

  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

  function automatic dsel_e next_dsel(
    input logic       s1,
    input logic       s2,
    input logic [1:0] trans
  );
    dsel_e d;
    d = DSEL_NONE;
    unique case (1'b1)
      s1:                d = DSEL_S1;
      (!s1 && s2):       d = DSEL_S2;
      (!s1 && !s2 &&
        is_active(trans)): d = DSEL_DEF;
      default:           d = DSEL_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with a
// two-cycle ERROR response (one stall, then completion).
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic H_clk,
  input  logic H_resetn,
  input  logic sel_def,
  input  logic H_ready,
  output logic hready_def,
  output logic hresp_def
);

  dstate_e state;
  logic    take;

  assign take = sel_def && H_ready;

  always_ff @(posedge H_clk or negedge H_resetn) begin
    if (!H_resetn) begin
      state      <= D_IDLE;
      hready_def <= 1'b1;
      hresp_def  <= HRESP_OKAY;
    end else begin
      unique case (state)
        D_ERR1: begin
          state      <= D_ERR2;
          hready_def <= 1'b1;
          hresp_def  <= HRESP_ERROR;
        end
        D_IDLE,
        D_ERR2: begin
          if (take) begin
            state      <= D_ERR1;
            hready_def <= 1'b0;
            hresp_def  <= HRESP_ERROR;
          end else begin
            state      <= D_IDLE;
            hready_def <= 1'b1;
            hresp_def  <= HRESP_OKAY;
          end
        end
        default: begin
          state      <= D_IDLE;
          hready_def <= 1'b1;
          hresp_def  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// Slave-to-master response mux: data-phase select register,
// default slave, and output steering.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              H_clk,
  input  logic              H_resetn,
  input  logic [1:0]        H_trans,
  input  logic              hsel_s1,
  input  logic              hsel_s2,
  input  logic [DATA_W-1:0] hrdata_s1,
  input  logic              hready_s1,
  input  logic              hresp_s1,
  input  logic [DATA_W-1:0] hrdata_s2,
  input  logic              hready_s2,
  input  logic              hresp_s2,
  output logic [DATA_W-1:0] H_rdata,
  output logic              H_ready,
  output logic              H_resp
);

  dsel_e dsel;
  dsel_e dsel_nxt;
  logic  sel_def;
  logic  hready_def;
  logic  hresp_def;

  assign dsel_nxt = next_dsel(hsel_s1, hsel_s2, H_trans);
  assign sel_def  = H_ready && (dsel_nxt == DSEL_DEF);

  // Address phase is only accepted while the current data phase completes
  always_ff @(posedge H_clk or negedge H_resetn) begin
    if (!H_resetn) begin
      dsel <= DSEL_NONE;
    end else if (H_ready) begin
      dsel <= dsel_nxt;
    end
  end

  ahb_default_slave u_def (
    .H_clk      (H_clk),
    .H_resetn   (H_resetn),
    .sel_def    (sel_def),
    .H_ready    (H_ready),
    .hready_def (hready_def),
    .hresp_def  (hresp_def)
  );

  always_comb begin
    H_rdata = '0;
    H_ready = 1'b1;
    H_resp  = HRESP_OKAY;
    unique case (dsel)
      DSEL_S1: begin
        H_rdata = hrdata_s1;
        H_ready = hready_s1;
        H_resp  = hresp_s1;
      end
      DSEL_S2: begin
        H_rdata = hrdata_s2;
        H_ready = hready_s2;
        H_resp  = hresp_s2;
      end
      DSEL_DEF: begin
        H_ready = hready_def;
        H_resp  = hresp_def;
      end
      default: begin
        H_rdata = '0;
        H_ready = 1'b1;
        H_resp  = HRESP_OKAY;
      end
    endcase
  end

endmodule
